// File: rtl/dma_rr_arbiter_if.sv
// Requester/controller side signals of the DMA read/write controller arbiter.
interface dma_rr_arbiter_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 rdWrCtlrIdle;
  logic                 burstDone;
  logic                 rxListProcReq;
  logic                 txStaUpdaterReq;
  logic                 txListProcReq;
  logic                 rxListProcGrant;
  logic                 txStaUpdaterGrant;
  logic                 txListProcGrant;
  logic                 arbPreempt;
  logic [CNT_WIDTH-1:0] arbBurstCnt;

  modport slave (
    input  rdWrCtlrIdle, burstDone, rxListProcReq, txStaUpdaterReq, txListProcReq,
    output rxListProcGrant, txStaUpdaterGrant, txListProcGrant, arbPreempt, arbBurstCnt
  );

  modport master (
    output rdWrCtlrIdle, burstDone, rxListProcReq, txStaUpdaterReq, txListProcReq,
    input  rxListProcGrant, txStaUpdaterGrant, txListProcGrant, arbPreempt, arbBurstCnt
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Three-way round-robin arbiter for the DMA read/write controller with burst-quantum preemption.
// Optional RW_DMA_ARB_RX_PRIO_EN: rx list processor wins every arbitration and is never preempted.
module dma_rr_arbiter #(
  parameter int QUANTUM   = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic              macPIClk,
  input  logic              macPIClkSoftRst_n,
  dma_rr_arbiter_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [CNT_WIDTH-1:0] QMAX = CNT_WIDTH'(QUANTUM);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 preempt_q, preempt_d;

  logic [2:0] req;
  logic [2:0] own_oh;
  logic [1:0] pick;
  logic       own_req, other_req, preempt_ok;

  assign req = {bus.txListProcReq, bus.txStaUpdaterReq, bus.rxListProcReq};

  // Cyclic scan starting just after the last owner.
  always_comb begin
    pick = 2'd0;
    case (last_q)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`ifdef RW_DMA_ARB_RX_PRIO_EN
    if (req[0]) pick = 2'd0;
`endif
  end

  always_comb begin
    own_oh = 3'b000;
    case (owner_q)
      2'd0:    own_oh = 3'b001;
      2'd1:    own_oh = 3'b010;
      2'd2:    own_oh = 3'b100;
      default: own_oh = 3'b000;
    endcase
  end

  assign own_req   = |(req & own_oh);
  assign other_req = |(req & ~own_oh);

`ifdef RW_DMA_ARB_RX_PRIO_EN
  assign preempt_ok = (QUANTUM != 0) && (cnt_q == QMAX) && other_req &&
                      bus.rdWrCtlrIdle && own_req && (owner_q != 2'd0);
`else
  assign preempt_ok = (QUANTUM != 0) && (cnt_q == QMAX) && other_req &&
                      bus.rdWrCtlrIdle && own_req;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.rdWrCtlrIdle && (|req)) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped request wins over preemption: ordinary release, no pulse.
        if (!own_req) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (preempt_ok) begin
          state_d   = IDLE;
          last_d    = owner_q;
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (bus.burstDone && (cnt_q != QMAX)) begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge macPIClk) begin
    if (!macPIClkSoftRst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.rxListProcGrant   = (state_q == GRANT) && (owner_q == 2'd0);
  assign bus.txStaUpdaterGrant = (state_q == GRANT) && (owner_q == 2'd1);
  assign bus.txListProcGrant   = (state_q == GRANT) && (owner_q == 2'd2);
  assign bus.arbPreempt        = preempt_q;
  assign bus.arbBurstCnt       = cnt_q;
endmodule

// File: tb/tb_dma_rr_arbiter.sv
// Directed bench for dma_rr_arbiter; grants are compared as {tx,sta,rx}.
module tb_dma_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  dma_rr_arbiter_if #(.CNT_WIDTH(4)) bus();

  dma_rr_arbiter #(.QUANTUM(4), .CNT_WIDTH(4)) dut (
    .macPIClk          (clk),
    .macPIClkSoftRst_n (rst_n),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input logic [2:0] r);
    bus.rxListProcReq   = r[0];
    bus.txStaUpdaterReq = r[1];
    bus.txListProcReq   = r[2];
  endtask

  function automatic int gnt();
    return int'({bus.txListProcGrant, bus.txStaUpdaterGrant, bus.rxListProcGrant});
  endfunction

  task automatic pulse_burst();
    bus.burstDone = 1'b1;
    tick();
    bus.burstDone = 1'b0;
  endtask

  // Four bursts spaced three cycles apart; ends with the counter at the quantum.
  task automatic run_quantum(input int g);
    for (int b = 0; b < 4; b++) begin
      chk("q_gnt", gnt(), g);
      chk("q_cnt", int'(bus.arbBurstCnt), b);
      pulse_burst();
      chk("q_cnt_inc", int'(bus.arbBurstCnt), b + 1);
      chk("q_pre", int'(bus.arbPreempt), 0);
      if (b < 3) begin
        tick();
        tick();
      end
    end
  endtask

  task automatic handover(input int nxt);
    tick();
    chk("ho_gnt_low", gnt(), 0);
    chk("ho_pre", int'(bus.arbPreempt), 1);
    chk("ho_cnt", int'(bus.arbBurstCnt), 0);
    tick();
    chk("ho_gnt_next", gnt(), nxt);
    chk("ho_pre_end", int'(bus.arbPreempt), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rdWrCtlrIdle = 1'b1;
    bus.burstDone    = 1'b0;
    setreq(3'b000);
    tick();
    tick();
    chk("rst_gnt", gnt(), 0);
    chk("rst_pre", int'(bus.arbPreempt), 0);
    chk("rst_cnt", int'(bus.arbBurstCnt), 0);
    rst_n = 1'b1;

`ifndef RW_DMA_ARB_RX_PRIO_EN
    // All requesting, no bursts: rx owns indefinitely.
    setreq(3'b111);
    tick();
    chk("first_gnt", gnt(), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_gnt", gnt(), 1);
      chk("hold_pre", int'(bus.arbPreempt), 0);
    end

    // Quantum rotation rx -> sta -> tx -> rx.
    run_quantum(1); handover(2);
    run_quantum(2); handover(4);
    run_quantum(4); handover(1);

    // Owner drops in the same cycle preemption would fire: plain release.
    run_quantum(1);
    setreq(3'b110);
    tick();
    chk("drop_gnt", gnt(), 0);
    chk("drop_pre", int'(bus.arbPreempt), 0);
    tick();
    chk("drop_next", gnt(), 2);

    // Lone tx requester releasing after two bursts.
    setreq(3'b100);
    tick();
    chk("sta_rel", gnt(), 0);
    tick();
    chk("tx_gnt", gnt(), 4);
    pulse_burst();
    tick();
    pulse_burst();
    chk("tx_cnt2", int'(bus.arbBurstCnt), 2);
    chk("tx_gnt2", gnt(), 4);
    setreq(3'b000);
    tick();
    chk("tx_rel_gnt", gnt(), 0);
    chk("tx_rel_pre", int'(bus.arbPreempt), 0);
    chk("tx_rel_cnt", int'(bus.arbBurstCnt), 0);
    tick();
    chk("idle_gnt", gnt(), 0);

    // Quantum reached but controller busy: hold until idle.
    setreq(3'b010);
    tick();
    chk("sta_gnt", gnt(), 2);
    run_quantum(2);
    tick();
    chk("alone_gnt", gnt(), 2);
    chk("alone_pre", int'(bus.arbPreempt), 0);
    bus.rdWrCtlrIdle = 1'b0;
    setreq(3'b011);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("busy_gnt", gnt(), 2);
      chk("busy_pre", int'(bus.arbPreempt), 0);
    end
    bus.rdWrCtlrIdle = 1'b1;
    tick();
    chk("busy_rel_gnt", gnt(), 0);
    chk("busy_rel_pre", int'(bus.arbPreempt), 1);
    tick();
    chk("busy_next", gnt(), 1);

    // Soft reset mid-grant restores lastGrant so rx wins next.
    setreq(3'b111);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("srst_gnt", gnt(), 0);
    chk("srst_cnt", int'(bus.arbBurstCnt), 0);
    chk("srst_pre", int'(bus.arbPreempt), 0);
    rst_n = 1'b1;
    bus.rdWrCtlrIdle = 1'b0;
    tick();
    chk("srst_busy", gnt(), 0);
    bus.rdWrCtlrIdle = 1'b1;
    tick();
    chk("srst_next", gnt(), 1);
`else
    // tx at quantum; rx arrives and takes over, then is never preempted.
    setreq(3'b100);
    tick();
    chk("p_tx_gnt", gnt(), 4);
    run_quantum(4);
    setreq(3'b111);
    tick();
    chk("p_rel_gnt", gnt(), 0);
    chk("p_rel_pre", int'(bus.arbPreempt), 1);
    tick();
    chk("p_rx_gnt", gnt(), 1);
    for (int i = 0; i < 6; i++) begin
      pulse_burst();
      tick();
      chk("p_rx_hold", gnt(), 1);
      chk("p_rx_pre", int'(bus.arbPreempt), 0);
    end
    chk("p_rx_cnt", int'(bus.arbBurstCnt), 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
